// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline: byte-addressable data memory
// with byte/halfword/word loads and stores, feeding the MEM/WB pipeline register.
module mem_stage #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic [31:0]   i_ex_m_alu_result,
  input  logic [31:0]   i_ex_m_write_data,
  input  logic [4:0]    i_ex_m_rd,
  input  logic          i_ex_m_mem_read,
  input  logic          i_ex_m_mem_write,
  input  logic          i_ex_m_mem_to_reg,
  input  logic          i_ex_m_reg_write,
  input  logic [2:0]    i_ex_m_bhw_type,
  input  logic [AW-1:0] i_du_mem_addr,
  output logic [31:0]   o_du_mem_data,
  output logic [31:0]   o_m_wb_read_data,
  output logic [31:0]   o_m_wb_alu_result,
  output logic [31:0]   o_m_wb_data_write,
  output logic [4:0]    o_m_wb_rd,
  output logic          o_m_wb_reg_write,
  output logic          o_m_wb_mem_to_reg
);

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_read_data;
  logic [31:0]   r_alu_result;
  logic [31:0]   r_data_write;
  logic [4:0]    r_rd;
  logic          r_reg_write;
  logic          r_mem_to_reg;

  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_wb;

  // Upper address bits are dropped here, which makes addresses wrap.
  assign w_idx         = i_ex_m_alu_result[AW+1:2];
  assign w_word        = r_mem[w_idx];
  assign o_du_mem_data = r_mem[i_du_mem_addr];

  always_comb begin
    w_byte = w_word[7:0];
    case (i_ex_m_alu_result[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = i_ex_m_alu_result[1] ? w_word[31:16] : w_word[15:0];
    w_load = '0;
    if (i_ex_m_mem_read) begin
      case (i_ex_m_bhw_type[1:0])
        2'b00:   w_load = i_ex_m_bhw_type[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        2'b01:   w_load = i_ex_m_bhw_type[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        default: w_load = w_word;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_ex_m_write_data;
    case (i_ex_m_bhw_type[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_ex_m_alu_result[1:0];
        w_wdata = {4{i_ex_m_write_data[7:0]}};
      end
      2'b01: begin
        w_be    = i_ex_m_alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_ex_m_write_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_ex_m_write_data;
      end
    endcase
  end

  assign w_wb = i_ex_m_mem_to_reg ? w_load : i_ex_m_alu_result;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_data_write <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (i_enable) begin
      if (i_ex_m_mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
      r_read_data  <= w_load;
      r_alu_result <= i_ex_m_alu_result;
      r_data_write <= w_wb;
      r_rd         <= i_ex_m_rd;
      r_reg_write  <= i_ex_m_reg_write;
      r_mem_to_reg <= i_ex_m_mem_to_reg;
    end
  end

  assign o_m_wb_read_data  = r_read_data;
  assign o_m_wb_alu_result = r_alu_result;
  assign o_m_wb_data_write = r_data_write;
  assign o_m_wb_rd         = r_rd;
  assign o_m_wb_reg_write  = r_reg_write;
  assign o_m_wb_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written stall/reset
// sequences and random traffic against a byte-array memory model.
module tb_mem_stage;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NB    = 4 * DEPTH;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic [31:0]   i_ex_m_alu_result;
  logic [31:0]   i_ex_m_write_data;
  logic [4:0]    i_ex_m_rd;
  logic          i_ex_m_mem_read;
  logic          i_ex_m_mem_write;
  logic          i_ex_m_mem_to_reg;
  logic          i_ex_m_reg_write;
  logic [2:0]    i_ex_m_bhw_type;
  logic [AW-1:0] i_du_mem_addr;
  logic [31:0]   o_du_mem_data;
  logic [31:0]   o_m_wb_read_data;
  logic [31:0]   o_m_wb_alu_result;
  logic [31:0]   o_m_wb_data_write;
  logic [4:0]    o_m_wb_rd;
  logic          o_m_wb_reg_write;
  logic          o_m_wb_mem_to_reg;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_enable          (i_enable),
    .i_ex_m_alu_result (i_ex_m_alu_result),
    .i_ex_m_write_data (i_ex_m_write_data),
    .i_ex_m_rd         (i_ex_m_rd),
    .i_ex_m_mem_read   (i_ex_m_mem_read),
    .i_ex_m_mem_write  (i_ex_m_mem_write),
    .i_ex_m_mem_to_reg (i_ex_m_mem_to_reg),
    .i_ex_m_reg_write  (i_ex_m_reg_write),
    .i_ex_m_bhw_type   (i_ex_m_bhw_type),
    .i_du_mem_addr     (i_du_mem_addr),
    .o_du_mem_data     (o_du_mem_data),
    .o_m_wb_read_data  (o_m_wb_read_data),
    .o_m_wb_alu_result (o_m_wb_alu_result),
    .o_m_wb_data_write (o_m_wb_data_write),
    .o_m_wb_rd         (o_m_wb_rd),
    .o_m_wb_reg_write  (o_m_wb_reg_write),
    .o_m_wb_mem_to_reg (o_m_wb_mem_to_reg)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a flat little-endian byte array plus the expected MEM/WB contents.
  logic [7:0]  mdlMem [NB];
  logic [31:0] mRead, mAlu, mData;
  logic [4:0]  mRd;
  logic        mRw, mM2r;

  function automatic logic [31:0] mdlWord(input int base);
    return {mdlMem[base+3], mdlMem[base+2], mdlMem[base+1], mdlMem[base]};
  endfunction

  function automatic logic [31:0] mdlLoad(input logic [31:0] addr, input logic [2:0] bhw);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr) % NB;
    if (a < 0) a = a + NB;
    case (bhw[1:0])
      2'b00: begin
        b = mdlMem[a];
        return bhw[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        a = a - (a % 2);
        h = {mdlMem[a+1], mdlMem[a]};
        return bhw[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return mdlWord(a - (a % 4));
    endcase
  endfunction

  function automatic void mdlStore(input logic [31:0] addr, input logic [31:0] d, input logic [2:0] bhw);
    int a;
    a = int'(addr) % NB;
    if (a < 0) a = a + NB;
    case (bhw[1:0])
      2'b00: mdlMem[a] = d[7:0];
      2'b01: begin
        a = a - (a % 2);
        mdlMem[a]   = d[7:0];
        mdlMem[a+1] = d[15:8];
      end
      default: begin
        a = a - (a % 4);
        for (int k = 0; k < 4; k++) mdlMem[a+k] = d[8*k +: 8];
      end
    endcase
  endfunction

  function automatic void mdlReset();
    for (int k = 0; k < NB; k++) mdlMem[k] = 8'h0;
    mRead = '0; mAlu = '0; mData = '0; mRd = '0; mRw = 1'b0; mM2r = 1'b0;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one instruction for one clock and advances the model alongside it.
  task automatic applyStimulus(input logic en, input logic rst, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] rd, input logic mr,
                               input logic mw, input logic m2r, input logic rw,
                               input logic [2:0] bhw);
    logic [31:0] ld;
    i_enable          = en;
    i_reset           = rst;
    i_ex_m_alu_result = addr;
    i_ex_m_write_data = wd;
    i_ex_m_rd         = rd;
    i_ex_m_mem_read   = mr;
    i_ex_m_mem_write  = mw;
    i_ex_m_mem_to_reg = m2r;
    i_ex_m_reg_write  = rw;
    i_ex_m_bhw_type   = bhw;
    i_du_mem_addr     = addr[AW+1:2];
    ld = mr ? mdlLoad(addr, bhw) : 32'h0;
    @(posedge i_clk);
    #1;
    if (rst) begin
      mdlReset();
    end else if (en) begin
      if (mw) mdlStore(addr, wd, bhw);
      mRead = ld;
      mAlu  = addr;
      mData = m2r ? ld : addr;
      mRd   = rd;
      mRw   = rw;
      mM2r  = m2r;
    end
  endtask

  task automatic checkOutput(input string tag);
    check32({tag, ".read"},  o_m_wb_read_data,  mRead);
    check32({tag, ".alu"},   o_m_wb_alu_result, mAlu);
    check32({tag, ".data"},  o_m_wb_data_write, mData);
    check32({tag, ".rd"},    {27'h0, o_m_wb_rd}, {27'h0, mRd});
    check32({tag, ".rw"},    {31'h0, o_m_wb_reg_write}, {31'h0, mRw});
    check32({tag, ".m2r"},   {31'h0, o_m_wb_mem_to_reg}, {31'h0, mM2r});
    check32({tag, ".dbg"},   o_du_mem_data, mdlWord(4 * int'(i_du_mem_addr)));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [2:0]  bhw;
    logic [31:0] expRead;
    logic [31:0] expData;
  } vec_t;

  function automatic vec_t mkVec(input logic [31:0] a, input logic [31:0] wd, input logic mr,
                                 input logic mw, input logic m2r, input logic [2:0] bhw,
                                 input logic [31:0] er, input logic [31:0] ed);
    vec_t v;
    v.addr = a; v.wdata = wd; v.mr = mr; v.mw = mw; v.m2r = m2r; v.bhw = bhw;
    v.expRead = er; v.expData = ed;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    tbl[0]  = mkVec(32'h10,  32'hDEADBEEF, 0, 1, 0, 3'b011, 32'h0,        32'h10);
    tbl[1]  = mkVec(32'h10,  32'h0,        1, 0, 1, 3'b011, 32'hDEADBEEF, 32'hDEADBEEF);
    tbl[2]  = mkVec(32'h20,  32'h11223344, 0, 1, 0, 3'b011, 32'h0,        32'h20);
    tbl[3]  = mkVec(32'h21,  32'h000000AA, 0, 1, 0, 3'b000, 32'h0,        32'h21);
    tbl[4]  = mkVec(32'h20,  32'h0,        1, 0, 1, 3'b011, 32'h1122AA44, 32'h1122AA44);
    tbl[5]  = mkVec(32'h21,  32'h0,        1, 0, 1, 3'b000, 32'hFFFFFFAA, 32'hFFFFFFAA);
    tbl[6]  = mkVec(32'h21,  32'h0,        1, 0, 1, 3'b100, 32'h000000AA, 32'h000000AA);
    tbl[7]  = mkVec(32'h22,  32'h0,        1, 0, 1, 3'b001, 32'h00001122, 32'h00001122);
    tbl[8]  = mkVec(32'h22,  32'h00008001, 0, 1, 0, 3'b001, 32'h0,        32'h22);
    tbl[9]  = mkVec(32'h22,  32'h0,        1, 0, 1, 3'b001, 32'hFFFF8001, 32'hFFFF8001);
    tbl[10] = mkVec(32'h23,  32'h0,        1, 0, 1, 3'b101, 32'h00008001, 32'h00008001);
    tbl[11] = mkVec(32'h5,   32'h0,        0, 0, 0, 3'b011, 32'h0,        32'h5);
    tbl[12] = mkVec(32'h20,  32'h0,        1, 0, 1, 3'b011, 32'h8001AA44, 32'h8001AA44);
    tbl[13] = mkVec(32'h20,  32'h0,        1, 0, 1, 3'b000, 32'h00000044, 32'h00000044);
    tbl[14] = mkVec(32'h108, 32'h00000077, 0, 1, 0, 3'b011, 32'h0,        32'h108);
    tbl[15] = mkVec(32'h8,   32'h0,        1, 0, 1, 3'b011, 32'h00000077, 32'h00000077);
    tbl[16] = mkVec(32'h22,  32'h0,        1, 0, 1, 3'b010, 32'h8001AA44, 32'h8001AA44);
    tbl[17] = mkVec(32'h20,  32'h0,        0, 0, 1, 3'b011, 32'h0,        32'h0);

    mdlReset();
    applyStimulus(1, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 3'b011);
    checkOutput("reset0");

    for (int i = 0; i < 18; i++) begin
      applyStimulus(1, 0, tbl[i].addr, tbl[i].wdata, i[4:0], tbl[i].mr, tbl[i].mw,
                    tbl[i].m2r, i[0], tbl[i].bhw);
      checkOutput($sformatf("vec%0d", i));
      check32($sformatf("vec%0d.tblRead", i), o_m_wb_read_data, tbl[i].expRead);
      check32($sformatf("vec%0d.tblData", i), o_m_wb_data_write, tbl[i].expData);
      check32($sformatf("vec%0d.tblRd", i), {27'h0, o_m_wb_rd}, i);
    end
    i_du_mem_addr = 6'd4;
    #1;
    check32("dbgWord4", o_du_mem_data, 32'hDEADBEEF);
    i_du_mem_addr = 6'd2;
    #1;
    check32("dbgWrapWord2", o_du_mem_data, 32'h00000077);

    // Reset colliding with a store: reset wins and every word reads back zero.
    applyStimulus(1, 1, 32'h10, 32'h99999999, 5'd9, 1, 1, 1, 1, 3'b011);
    checkOutput("rstStore");
    check32("rstStore.alu", o_m_wb_alu_result, 32'h0);
    for (int w = 0; w < DEPTH; w++) begin
      i_du_mem_addr = w[AW-1:0];
      #1;
      check32($sformatf("rstWord%0d", w), o_du_mem_data, 32'h0);
    end

    // Stall: a store held on the inputs must not land until enable returns.
    applyStimulus(1, 0, 32'hABC, 32'h0, 5'd3, 0, 0, 0, 1, 3'b011);
    checkOutput("preStall");
    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 0, 32'h0, 32'h1234, 5'd12, 0, 1, 0, 0, 3'b011);
      checkOutput($sformatf("stall%0d", s));
      check32($sformatf("stall%0d.alu", s), o_m_wb_alu_result, 32'hABC);
      check32($sformatf("stall%0d.rd", s), {27'h0, o_m_wb_rd}, 32'd3);
      check32($sformatf("stall%0d.mem0", s), o_du_mem_data, 32'h0);
    end
    applyStimulus(1, 0, 32'h0, 32'h1234, 5'd12, 0, 1, 0, 0, 3'b011);
    checkOutput("release");
    check32("release.mem0", o_du_mem_data, 32'h1234);
    check32("release.alu", o_m_wb_alu_result, 32'h0);

    applyStimulus(0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 3'b011);
    checkOutput("rstInStall");
    check32("rstInStall.mem0", o_du_mem_data, 32'h0);
    check32("rstInStall.rd", {27'h0, o_m_wb_rd}, 32'h0);

    for (int r = 0; r < 600; r++) begin
      logic [31:0] ra, rwd;
      logic [2:0]  rb;
      ra  = $urandom;
      rwd = $urandom;
      rb  = 3'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0), ra, rwd,
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), rb);
      checkOutput($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. It consumes the EX/MEM register contents (ALU result as address, store data, destination register, memory/writeback controls, byte/halfword/word type), performs loads and stores on an internal byte-addressable data memory, and registers the results into the MEM/WB pipeline register. That register feeds writeback and execute-stage forwarding. A read-only debug port exposes memory words to the debug unit.

## Interface
Parameters:
- `DEPTH`, 64: data memory size in 32-bit words; power of two.
- `AW`, 6: word-index width, log2(DEPTH).

Ports:
- `i_clk` in 1: clock; everything is rising-edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_enable` in 1: pipeline advance. When 0, stores are suppressed and MEM/WB holds its value.
- `i_ex_m_alu_result` in 32: byte address, or the value passed through to writeback.
- `i_ex_m_write_data` in 32: store data, already forwarded.
- `i_ex_m_rd` in 5: destination register.
- `i_ex_m_mem_read` in 1: load.
- `i_ex_m_mem_write` in 1: store.
- `i_ex_m_mem_to_reg` in 1: writeback selects the load data.
- `i_ex_m_reg_write` in 1: register-file write enable.
- `i_ex_m_bhw_type` in 3: bit2 = unsigned; bits[1:0] = 00 byte, 01 halfword, 11 word; 10 is treated as word.
- `i_du_mem_addr` in AW: debug word index.
- `o_du_mem_data` out 32: combinational read of the word at `i_du_mem_addr`.
- `o_m_wb_read_data` out 32: registered, extended load data.
- `o_m_wb_alu_result` out 32: registered ALU result.
- `o_m_wb_data_write` out 32: registered writeback value, equal to mem_to_reg ? read_data : alu_result.
- `o_m_wb_rd` out 5: registered destination register.
- `o_m_wb_reg_write` out 1: registered.
- `o_m_wb_mem_to_reg` out 1: registered.

## Operation
- Memory is DEPTH x 32-bit registers, little-endian.
  - Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- Alignment:
  - Word accesses ignore addr[1:0].
  - Halfword accesses ignore addr[0] and select lane addr[1].
  - Byte accesses select lane addr[1:0].
  - No misalignment trap.
- Store, when `i_ex_m_mem_write` & `i_enable` & !`i_reset`:
  - Byte: write_data[7:0] goes to the lane.
  - Halfword: write_data[15:0] goes to the half-lane.
  - Word: all 32 bits are written.
  - Other bytes of the word are preserved (byte-enable merge).
- Load: combinational read of the addressed word, then lane extraction.
  - If bit2 = 0, sign-extend; if bit2 = 1, zero-extend.
  - Word loads are unaffected by bit2.
  - If `i_ex_m_mem_read` = 0, the load data is 0.
- MEM/WB register: when `i_enable` = 1, captures load data, alu_result, the selected writeback value, rd, reg_write and mem_to_reg. When `i_enable` = 0, it holds.
- `i_ex_m_mem_read` and `i_ex_m_mem_write` both high is treated as a store; the load data is still computed from the pre-write contents.
- Debug read is independent of pipeline state.

## Timing
- Reset (synchronous): all MEM/WB outputs go to 0 and every memory word is cleared to 0. Reset wins over a simultaneous store.
- Store: memory is updated at the edge where the stage sees the instruction. A load to the same address in the following cycle returns the new data.
- Load latency: data appears on `o_m_wb_read_data` / `o_m_wb_data_write` one clock after the instruction is on the `i_ex_m_*` inputs.
- `o_du_mem_data` reflects a store immediately after the edge that performs it.
- Stall: while `i_enable` = 0, the outputs are frozen and memory is unchanged. On release, the instruction present on the inputs completes normally.
- Reset asserted during a stall still clears everything.

## Test plan
- Reset: drive activity, assert `i_reset` for 1 cycle -> all outputs 0; debug reads of words 0..DEPTH-1 return 0.
- Word store/load: SW 0xDEADBEEF @ addr 0x10, then LW @ 0x10 -> `o_m_wb_read_data` = 0xDEADBEEF, `o_du_mem_data`(idx 4) = 0xDEADBEEF.
- Byte/half lanes and extension, starting from word 0x11223344 @ 0x20:
  - SB 0xAA @ 0x21 -> word = 0x1122AA44.
  - LB @ 0x21 -> 0xFFFFFFAA.
  - LBU @ 0x21 -> 0x000000AA.
  - LH @ 0x22 -> 0x00001122.
  - SH 0x8001 @ 0x22 then LH @ 0x22 -> 0xFFFF8001.
- Writeback select:
  - R-type with alu_result 0x5, mem_to_reg = 0, rd = 7, reg_write = 1 -> `o_m_wb_data_write` = 0x5, `o_m_wb_rd` = 7.
  - A following load with mem_to_reg = 1 -> `o_m_wb_data_write` = load data.
- Stall:
  - `i_enable` = 0 with SW 0x1234 @ 0x0 presented for 3 cycles -> memory word 0 unchanged and outputs frozen.
  - Raise `i_enable` -> the store lands in 1 cycle.
- Wrap and collision:
  - SW 0x77 @ 4*DEPTH+8 -> lands in word 2.
  - Store with simultaneous reset -> word stays 0.
